pipeline_hazard_controller: RTL and testbench



---
 rtl/pipeline_pkg.sv | 49 ++++
 rtl/pipeline_hazard_controller_if.sv | 40 ++++
 rtl/load_use_detector.sv | 21 ++
 rtl/pipeline_hazard_controller.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the hazard controller and its neighbours.
// Holds the FSM encoding, the ID/EX control-word field map and the pipeline control bundle.
package pipeline_pkg;

  localparam int REG_W       = 3;
  localparam int NUM_SRC     = 2;
  localparam int PC_W        = 32;
  localparam int FLUSH_CNT_W = 2;

  // Bit positions inside the ID/EX control word.
  localparam int ID_EX_STACK_PC_BIT    = 89;
  localparam int ID_EX_STACK_FLAGS_BIT = 90;
  localparam int ID_EX_MR_BIT          = 44;
  localparam int ID_EX_WB_ADDR_HI      = 43;
  localparam int ID_EX_WB_ADDR_LO      = 41;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_RUN            = 3'd0,
    S_FLUSH          = 3'd1,
    S_INT_DRAIN      = 3'd2,
    S_INT_PUSH_PC    = 3'd3,
    S_INT_PUSH_FLAGS = 3'd4,
    S_INT_VECTOR     = 3'd5
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic pc_load_vector;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic inject_stack_pc;
    logic inject_stack_flags;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // While reset is held both pipeline registers are forced to bubbles and nothing advances.
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c             = CTRL_NONE;
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the hazard controller and the pipeline it steers.
// slave is the controller side; master is the datapath (or a testbench) side.
interface pipeline_hazard_controller_if;
  import pipeline_pkg::*;

  logic [REG_W-1:0] IF_ID_Src1;
  logic [REG_W-1:0] IF_ID_Src2;
  logic             IF_ID_Use1;
  logic             IF_ID_Use2;
  logic             ID_EX_MR;
  logic [REG_W-1:0] ID_EX_WB_Address;
  logic             Taken_Jump;
  logic [PC_W-1:0]  IF_PC;
  logic             Interrupt;

  logic             PC_Write;
  logic             PC_Load_Vector;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             Inject_Stack_PC;
  logic             Inject_Stack_Flags;
  logic [PC_W-1:0]  Saved_PC;
  logic             Busy;

  modport slave (
    input  IF_ID_Src1, IF_ID_Src2, IF_ID_Use1, IF_ID_Use2,
           ID_EX_MR, ID_EX_WB_Address, Taken_Jump, IF_PC, Interrupt,
    output PC_Write, PC_Load_Vector, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
           Inject_Stack_PC, Inject_Stack_Flags, Saved_PC, Busy
  );

  modport master (
    output IF_ID_Src1, IF_ID_Src2, IF_ID_Use1, IF_ID_Use2,
           ID_EX_MR, ID_EX_WB_Address, Taken_Jump, IF_PC, Interrupt,
    input  PC_Write, PC_Load_Vector, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
           Inject_Stack_PC, Inject_Stack_Flags, Saved_PC, Busy
  );

endinterface

// File: rtl/load_use_detector.sv
// Combinational load-use compare: a load in EX whose destination is read by the instruction in ID.
// Kept standalone so the forwarding unit can reuse the same per-source compare.
module load_use_detector
  import pipeline_pkg::*;
(
  input  logic [NUM_SRC-1:0][REG_W-1:0] src,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic                          mem_read,
  input  logic [REG_W-1:0]              wb_address,
  output logic                          load_use
);

  logic [NUM_SRC-1:0] hit;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign hit[gi] = src_used[gi] && (src[gi] == wb_address);
  end

  assign load_use = mem_read && (|hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the ID/EX -> EX -> EX/MEM path: load-use bubble, jump flush
// and the four-step interrupt entry (drain, push PC, push flags, load vector).
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] INT_VECTOR   = 32'd0
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_hazard_controller_if.slave  hz
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..3");
  end
  // The vector itself is consumed by the PC mux; it must at least be a defined address.
  if ((^INT_VECTOR) === 1'bx) begin : g_bad_vector
    $error("INT_VECTOR must be fully defined");
  end

  state_t                 state_reg, state_next;
  logic                   pending_reg, pending_next;
  logic [PC_W-1:0]        saved_pc_reg, saved_pc_next;
  logic [FLUSH_CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  ctrl_t                  ctrl;
  logic                   load_use;

  load_use_detector u_load_use (
    .src        ({hz.IF_ID_Src2, hz.IF_ID_Src1}),
    .src_used   ({hz.IF_ID_Use2, hz.IF_ID_Use1}),
    .mem_read   (hz.ID_EX_MR),
    .wb_address (hz.ID_EX_WB_Address),
    .load_use   (load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_RUN;
      pending_reg   <= 1'b0;
      saved_pc_reg  <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      saved_pc_reg  <= saved_pc_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pending_next   = pending_reg | hz.Interrupt;
    saved_pc_next  = saved_pc_reg;
    flush_cnt_next = flush_cnt_reg;
    ctrl           = CTRL_NONE;

    case (state_reg)
      S_RUN: begin
        if (hz.Taken_Jump) begin
          // PC keeps advancing so it picks up the jump target from the PC mux.
          ctrl.pc_write    = 1'b1;
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next     = S_FLUSH;
            flush_cnt_next = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (load_use) begin
          ctrl.id_ex_flush = 1'b1;
        end else if (pending_reg || hz.Interrupt) begin
          // The instruction now in IF is the return point; the drain squashes it.
          ctrl.pc_write    = 1'b1;
          ctrl.if_id_write = 1'b1;
          saved_pc_next    = hz.IF_PC;
          pending_next     = 1'b0;
          state_next       = S_INT_DRAIN;
        end else begin
          ctrl.pc_write    = 1'b1;
          ctrl.if_id_write = 1'b1;
        end
      end

      S_FLUSH: begin
        ctrl.pc_write    = 1'b1;
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
        if (flush_cnt_reg <= FLUSH_CNT_W'(1)) begin
          flush_cnt_next = '0;
          state_next     = S_RUN;
        end else begin
          flush_cnt_next = flush_cnt_reg - FLUSH_CNT_W'(1);
        end
      end

      S_INT_DRAIN: begin
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
        // An older jump resolving now redirects IF; the return point follows it.
        if (hz.Taken_Jump) begin
          saved_pc_next = hz.IF_PC;
        end
        state_next = S_INT_PUSH_PC;
      end

      S_INT_PUSH_PC: begin
        ctrl.if_id_flush     = 1'b1;
        ctrl.inject_stack_pc = 1'b1;
        state_next           = S_INT_PUSH_FLAGS;
      end

      S_INT_PUSH_FLAGS: begin
        ctrl.if_id_flush        = 1'b1;
        ctrl.inject_stack_flags = 1'b1;
        state_next              = S_INT_VECTOR;
      end

      S_INT_VECTOR: begin
        ctrl.pc_write       = 1'b1;
        ctrl.pc_load_vector = 1'b1;
        ctrl.if_id_flush    = 1'b1;
        state_next          = S_RUN;
      end

      default: begin
        state_next = S_RUN;
      end
    endcase

    if (reset) begin
      ctrl = ctrl_reset();
    end
  end

  assign hz.PC_Write           = ctrl.pc_write;
  assign hz.PC_Load_Vector     = ctrl.pc_load_vector;
  assign hz.IF_ID_Write        = ctrl.if_id_write;
  assign hz.IF_ID_Flush        = ctrl.if_id_flush;
  assign hz.ID_EX_Flush        = ctrl.id_ex_flush;
  assign hz.Inject_Stack_PC    = ctrl.inject_stack_pc;
  assign hz.Inject_Stack_Flags = ctrl.inject_stack_flags;
  assign hz.Saved_PC           = saved_pc_reg;
  assign hz.Busy               = (state_reg != S_RUN) && !reset;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Cycle-by-cycle vector bench for pipeline_hazard_controller with FLUSH_CYCLES=2.
// Each applied cycle queues its expected outputs; the negedge checker pops and compares.
module tb_pipeline_hazard_controller;

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic        use1;
    logic        use2;
    logic        mr;
    logic [2:0]  wb;
    logic        jump;
    logic [31:0] pc;
    logic        intr;
    logic [7:0]  exp_ctrl;
    logic [31:0] exp_saved;
  } vec_t;

  // {PC_Write, PC_Load_Vector, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Inj_PC, Inj_Flags, Busy}
  localparam logic [7:0] RST  = 8'b0001_1000;
  localparam logic [7:0] NORM = 8'b1010_0000;
  localparam logic [7:0] LUB  = 8'b0000_1000;
  localparam logic [7:0] JMP  = 8'b1001_1000;
  localparam logic [7:0] FLS  = 8'b1001_1001;
  localparam logic [7:0] DRN  = 8'b0001_1001;
  localparam logic [7:0] PPC  = 8'b0001_0101;
  localparam logic [7:0] PFL  = 8'b0001_0011;
  localparam logic [7:0] VEC  = 8'b1101_0001;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t sb[$];
  vec_t tbl[12];

  pipeline_hazard_controller_if hz();

  pipeline_hazard_controller #(
    .FLUSH_CYCLES (2),
    .INT_VECTOR   (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(string name, logic rst, logic [2:0] src1, logic use1,
                              logic [2:0] src2, logic use2, logic mr, logic [2:0] wb,
                              logic jump, logic [31:0] pc, logic intr,
                              logic [7:0] exp_ctrl, logic [31:0] exp_saved);
    vec_t v;
    v.name = name; v.rst = rst; v.src1 = src1; v.use1 = use1; v.src2 = src2;
    v.use2 = use2; v.mr = mr; v.wb = wb; v.jump = jump; v.pc = pc; v.intr = intr;
    v.exp_ctrl = exp_ctrl; v.exp_saved = exp_saved;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    reset               = v.rst;
    hz.IF_ID_Src1       = v.src1;
    hz.IF_ID_Src2       = v.src2;
    hz.IF_ID_Use1       = v.use1;
    hz.IF_ID_Use2       = v.use2;
    hz.ID_EX_MR         = v.mr;
    hz.ID_EX_WB_Address = v.wb;
    hz.Taken_Jump       = v.jump;
    hz.IF_PC            = v.pc;
    hz.Interrupt        = v.intr;
    sb.push_back(v);
  endtask

  // Plain cycle with only IF_PC / Interrupt / Taken_Jump varying.
  task automatic step(input string name, input logic [31:0] pc, input logic intr,
                      input logic jump, input logic rst, input logic [7:0] ec,
                      input logic [31:0] es);
    apply(mk(name, rst, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, jump, pc, intr, ec, es));
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      vec_t e;
      logic [7:0] act;
      e   = sb.pop_front();
      act = {hz.PC_Write, hz.PC_Load_Vector, hz.IF_ID_Write, hz.IF_ID_Flush,
             hz.ID_EX_Flush, hz.Inject_Stack_PC, hz.Inject_Stack_Flags, hz.Busy};
      total = total + 2;
      if (act !== e.exp_ctrl) begin
        bad = bad + 1;
        $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.exp_ctrl);
      end else begin
        $display("ok   %s ctrl=%b", e.name, act);
      end
      if (hz.Saved_PC !== e.exp_saved) begin
        bad = bad + 1;
        $display("FAIL %s saved_pc: got %0d expected %0d", e.name, hz.Saved_PC, e.exp_saved);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    hz.IF_ID_Src1 = '0; hz.IF_ID_Src2 = '0; hz.IF_ID_Use1 = 1'b0; hz.IF_ID_Use2 = 1'b0;
    hz.ID_EX_MR = 1'b0; hz.ID_EX_WB_Address = '0; hz.Taken_Jump = 1'b0;
    hz.IF_PC = '0; hz.Interrupt = 1'b0;

    //          name          rst src1 u1 src2 u2 mr  wb   jmp pc      int  ctrl  saved
    tbl[0]  = mk("reset",      1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 32'd0,  0, RST,  32'd0);
    tbl[1]  = mk("reset_int",  1, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 32'd0,  1, RST,  32'd0);
    tbl[2]  = mk("idle",       0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 32'd1,  0, NORM, 32'd0);
    tbl[3]  = mk("lu_src1",    0, 3'd3, 1, 3'd0, 0, 1, 3'd3, 0, 32'd2,  0, LUB,  32'd0);
    tbl[4]  = mk("lu_cleared", 0, 3'd3, 1, 3'd0, 0, 0, 3'd3, 0, 32'd2,  0, NORM, 32'd0);
    tbl[5]  = mk("lu_src2",    0, 3'd0, 0, 3'd5, 1, 1, 3'd5, 0, 32'd3,  0, LUB,  32'd0);
    tbl[6]  = mk("src2_unused",0, 3'd0, 0, 3'd5, 0, 1, 3'd5, 0, 32'd3,  0, NORM, 32'd0);
    tbl[7]  = mk("no_match",   0, 3'd3, 1, 3'd4, 1, 1, 3'd2, 0, 32'd4,  0, NORM, 32'd0);
    tbl[8]  = mk("match_no_mr",0, 3'd3, 1, 3'd0, 0, 0, 3'd3, 0, 32'd5,  0, NORM, 32'd0);
    tbl[9]  = mk("jump",       0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 32'd6,  0, JMP,  32'd0);
    tbl[10] = mk("flush_jump", 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 1, 32'd7,  0, FLS,  32'd0);
    tbl[11] = mk("after_jump", 0, 3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 32'd8,  0, NORM, 32'd0);
    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // Single interrupt pulse: accept, drain, push PC, push flags, vector, back to RUN.
    step("int_accept", 32'd15, 1, 0, 0, NORM, 32'd0);
    step("int_drain",  32'd16, 0, 0, 0, DRN,  32'd15);
    step("int_pushpc", 32'd16, 0, 0, 0, PPC,  32'd15);
    step("int_pushfl", 32'd16, 0, 0, 0, PFL,  32'd15);
    step("int_vector", 32'd16, 0, 0, 0, VEC,  32'd15);
    step("int_run",    32'd17, 0, 0, 0, NORM, 32'd15);

    // Jump + load-use + interrupt together: flush wins, the request stays pending.
    apply(mk("simul_jump", 0, 3'd1, 1, 3'd0, 0, 1, 3'd1, 1, 32'd40, 1, JMP, 32'd15));
    step("simul_flush",  32'd41, 0, 0, 0, FLS,  32'd15);
    step("simul_accept", 32'd44, 0, 0, 0, NORM, 32'd15);
    // Older jump resolves during drain: return PC is re-captured.
    step("drain_jump",   32'd50, 0, 1, 0, DRN,  32'd44);
    // Second request during PUSH_PC re-enters right after the vector fetch.
    step("b2b_pushpc",   32'd51, 1, 0, 0, PPC,  32'd50);
    step("b2b_pushfl",   32'd51, 0, 0, 0, PFL,  32'd50);
    step("b2b_vector",   32'd51, 0, 0, 0, VEC,  32'd50);
    step("b2b_accept",   32'd60, 0, 0, 0, NORM, 32'd50);
    step("b2b_drain",    32'd61, 0, 0, 0, DRN,  32'd60);
    step("b2b_pushpc2",  32'd61, 0, 0, 0, PPC,  32'd60);
    // Reset during PUSH_FLAGS aborts the entry.
    step("rst_pushfl",   32'd61, 0, 0, 1, RST,  32'd60);
    step("rst_after",    32'd62, 0, 0, 0, NORM, 32'd0);
    step("rst_after2",   32'd63, 0, 0, 0, NORM, 32'd0);

    // Load-use outranks an interrupt; the request is taken once the bubble clears EX.
    apply(mk("lu_int",    0, 3'd7, 1, 3'd0, 0, 1, 3'd7, 0, 32'd70, 1, LUB, 32'd0));
    step("lu_int_accept", 32'd70, 0, 0, 0, NORM, 32'd0);
    step("lu_int_drain",  32'd71, 0, 0, 0, DRN,  32'd70);
    step("lu_int_pushpc", 32'd71, 0, 0, 0, PPC,  32'd70);
    step("lu_int_pushfl", 32'd71, 0, 0, 0, PFL,  32'd70);
    step("lu_int_vector", 32'd71, 0, 0, 0, VEC,  32'd70);
    step("lu_int_run",    32'd72, 0, 0, 0, NORM, 32'd70);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
